// File: rtl/ysyx_22040237_exu_ctrl_pkg.sv
// Shared encodings for the execute-stage controller and its M-extension engine.
// Opcode and state values are fixed; the datapath width aliases XLEN.
package ysyx_22040237_exu_ctrl_pkg;

  localparam int ysyx_22040237_REG_WIDTH = 64;
  localparam int CNT_WIDTH = 7;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } exu_state_e;

endpackage

// File: rtl/ysyx_22040237_exu_ctrl_mdu_iter.sv
// Radix-2 multiply/divide engine: shift-add product, restoring division.
// Outputs are taken from the next accumulator so the last step is visible at once.
module ysyx_22040237_mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              abort,
  input  logic              is_div,
  input  logic              word,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quo,
  output logic [XLEN-1:0]   rem
);

  localparam int W = 2 * XLEN;
  localparam int H = XLEN / 2;

  logic [W-1:0]    acc;
  logic [W-1:0]    acc_nxt;
  logic [W-1:0]    sh;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] b_q;
  logic            div_q;
  logic            word_q;

  always_comb begin
    sum  = {1'b0, acc[W-1:XLEN]}
         + (acc[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    sh   = {acc[W-2:0], 1'b0};
    diff = acc[W-1:XLEN-1] - {1'b0, b_q};
    if (div_q) begin
      acc_nxt = diff[XLEN] ? sh
              : {diff[XLEN-1:0], sh[XLEN-1:1], 1'b1};
    end else begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end
  end

  // a 32-step multiply leaves the product parked 32 bits up
  assign prod = word_q ? {{H{1'b0}}, acc_nxt[W-1:H]} : acc_nxt;
  assign quo  = acc_nxt[XLEN-1:0];
  assign rem  = acc_nxt[W-1:XLEN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      word_q <= 1'b0;
    end else if (abort) begin
      acc <= '0;
    end else if (start) begin
      acc    <= {{XLEN{1'b0}}, (is_div & word) ? (a << H) : a};
      b_q    <= b;
      div_q  <= is_div;
      word_q <= word;
    end else if (step) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/ysyx_22040237_exu_ctrl.sv
// Execute-stage sequencer: 1-cycle ALU issue, iterative M-extension ops,
// IDU/WBU handshakes and a single registered writeback entry.
module ysyx_22040237_exu_ctrl
  import ysyx_22040237_exu_ctrl_pkg::*;
#(
  parameter int XLEN  = ysyx_22040237_REG_WIDTH,
  parameter int CNT_W = CNT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            in_is_mdu_i,
  input  logic [2:0]      mdu_op_i,
  input  logic            mdu_word_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic            rd_wr_en_i,
  input  logic [4:0]      rd_idx_i,
  input  logic            kill_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic            wb_rd_wr_en_o,
  output logic [4:0]      wb_rd_idx_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            stall_o
);

  localparam int H = XLEN / 2;

  exu_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op_q;
  logic            word_q, neg_q, rd_wr_q;
  logic [4:0]      rd_q;

  logic            accept, start, last;
  logic            sgn1, sgn2, neg1, neg2, is_rem, div_zero, ovf, sc;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, sc_raw, sc_res;
  logic [XLEN-1:0] fin_raw, fin_res, quo, rem, q_fix, r_fix;
  logic [2*XLEN-1:0] prod, p_fix;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{H{v[H-1]}}, v[H-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
    return {{H{1'b0}}, v[H-1:0]};
  endfunction

  // operand conditioning at issue time
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    unique case (1'b1)
      mdu_op_i == MDU_MULH:              begin sgn1 = 1'b1; sgn2 = 1'b1; end
      mdu_op_i == MDU_MULHSU:            sgn1 = 1'b1;
      mdu_op_i == MDU_DIV,
      mdu_op_i == MDU_REM:               begin sgn1 = 1'b1; sgn2 = 1'b1; end
      default: ;
    endcase
    ext1 = !mdu_word_i ? op1_i : sgn1 ? sext_w(op1_i) : zext_w(op1_i);
    ext2 = !mdu_word_i ? op2_i : sgn2 ? sext_w(op2_i) : zext_w(op2_i);
    neg1 = sgn1 & ext1[XLEN-1];
    neg2 = sgn2 & ext2[XLEN-1];
    mag1 = neg1 ? -ext1 : ext1;
    mag2 = neg2 ? -ext2 : ext2;
    is_rem   = mdu_op_i[2] & mdu_op_i[1];
    div_zero = mdu_op_i[2] & (ext2 == '0);
    ovf      = mdu_op_i[2] & sgn2 & (ext2 == '1)
             & (ext1 == (mdu_word_i ? sext_w({1'b1, {(XLEN-1){1'b0}}} >> H)
                                    : {1'b1, {(XLEN-1){1'b0}}}));
    sc       = div_zero | ovf;
    sc_raw   = is_rem ? (div_zero ? ext1 : '0)
                      : (div_zero ? '1 : ext1);
    sc_res   = mdu_word_i ? sext_w(sc_raw) : sc_raw;
  end

  assign accept = in_valid_i & in_ready_o;
  assign start  = accept & in_is_mdu_i & !sc;
  assign last   = (state == ST_BUSY)
                & (cnt == (word_q ? CNT_W'(H - 1) : CNT_W'(XLEN - 1)));

  ysyx_22040237_mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .step   (state == ST_BUSY),
    .abort  (kill_i),
    .is_div (mdu_op_i[2]),
    .word   (mdu_word_i),
    .a      (mag1),
    .b      (mag2),
    .prod   (prod),
    .quo    (quo),
    .rem    (rem)
  );

  always_comb begin
    p_fix = neg_q ? -prod : prod;
    q_fix = neg_q ? -quo : quo;
    r_fix = neg_q ? -rem : rem;
    unique case (op_q)
      MDU_MUL:                       fin_raw = p_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fin_raw = p_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:             fin_raw = q_fix;
      default:                       fin_raw = r_fix;
    endcase
    fin_res = word_q ? sext_w(fin_raw) : fin_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (kill_i) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (start) state_nxt = ST_BUSY;
        ST_BUSY: if (last)  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o = (state == ST_IDLE) & (!wb_valid_o | wb_ready_i) & !kill_i;
    stall_o    = !in_ready_o;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      op_q          <= '0;
      word_q        <= 1'b0;
      neg_q         <= 1'b0;
      rd_wr_q       <= 1'b0;
      rd_q          <= '0;
      wb_valid_o    <= 1'b0;
      wb_rd_wr_en_o <= 1'b0;
      wb_rd_idx_o   <= '0;
      wb_data_o     <= '0;
    end else if (kill_i) begin
      cnt        <= '0;
      wb_valid_o <= 1'b0;
    end else begin
      if (wb_valid_o & wb_ready_i) wb_valid_o <= 1'b0;
      if (accept) begin
        cnt     <= '0;
        op_q    <= mdu_op_i;
        word_q  <= mdu_word_i;
        neg_q   <= is_rem ? neg1 : (neg1 ^ neg2);
        rd_wr_q <= rd_wr_en_i;
        rd_q    <= rd_idx_i;
        if (!in_is_mdu_i || sc) begin
          wb_valid_o    <= 1'b1;
          wb_rd_wr_en_o <= rd_wr_en_i;
          wb_rd_idx_o   <= rd_idx_i;
          wb_data_o     <= in_is_mdu_i ? sc_res : alu_res_i;
        end
      end else if (state == ST_BUSY) begin
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          wb_valid_o    <= 1'b1;
          wb_rd_wr_en_o <= rd_wr_q;
          wb_rd_idx_o   <= rd_q;
          wb_data_o     <= fin_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_exu_ctrl.sv
// Directed bench for the execute-stage controller.
// Hand-computed vectors cover ALU issue, backpressure, M-ops, kill and reset.
module tb_ysyx_22040237_exu_ctrl;
  import ysyx_22040237_exu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o, in_is_mdu_i;
  logic [2:0]  mdu_op_i;
  logic        mdu_word_i;
  logic [63:0] op1_i, op2_i, alu_res_i;
  logic        rd_wr_en_i;
  logic [4:0]  rd_idx_i;
  logic        kill_i;
  logic        wb_valid_o, wb_ready_i, wb_rd_wr_en_o;
  logic [4:0]  wb_rd_idx_o;
  logic [63:0] wb_data_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  ysyx_22040237_exu_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_is_mdu_i(in_is_mdu_i), .mdu_op_i(mdu_op_i),
    .mdu_word_i(mdu_word_i), .op1_i(op1_i), .op2_i(op2_i),
    .alu_res_i(alu_res_i), .rd_wr_en_i(rd_wr_en_i),
    .rd_idx_i(rd_idx_i), .kill_i(kill_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_wr_en_o(wb_rd_wr_en_o), .wb_rd_idx_o(wb_rd_idx_o),
    .wb_data_o(wb_data_o), .stall_o(stall_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mdu, input logic [2:0] op,
                       input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] alu,
                       input logic [4:0] rd, input logic we);
    in_valid_i  = 1'b1;
    in_is_mdu_i = mdu;
    mdu_op_i    = op;
    mdu_word_i  = w;
    op1_i       = a;
    op2_i       = b;
    alu_res_i   = alu;
    rd_idx_i    = rd;
    rd_wr_en_i  = we;
  endtask

  // accept at the next edge, then count edges until wb_valid_o shows up
  task automatic issue(input logic mdu, input logic [2:0] op,
                       input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] alu,
                       input logic [4:0] rd, output int n);
    drive(mdu, op, w, a, b, alu, rd, 1'b1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    n = 0;
    while (!wb_valid_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid_i = 1'b0; in_is_mdu_i = 1'b0; mdu_op_i = '0;
    mdu_word_i = 1'b0; op1_i = '0; op2_i = '0; alu_res_i = '0;
    rd_wr_en_i = 1'b0; rd_idx_i = '0; kill_i = 1'b0; wb_ready_i = 1'b1;
    #2;
    chk("rst_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_data", wb_data_o, 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 3'd0, 1'b0, 64'd0, 64'd0, 64'h1234, 5'd5, lat);
    chk("alu_lat", 64'(lat), 64'd0);
    chk("alu_data", wb_data_o, 64'h1234);
    chk("alu_rd", 64'(wb_rd_idx_o), 64'd5);
    chk("alu_ready", 64'(in_ready_o), 64'd1);

    drive(1'b0, 3'd0, 1'b0, 64'd0, 64'd0, 64'hABCD, 5'd7, 1'b1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    wb_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data", wb_data_o, 64'hABCD);
      chk("bp_valid", 64'(wb_valid_o), 64'd1);
      chk("bp_stall", 64'(stall_o), 64'd1);
      chk("bp_ready", 64'(in_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    wb_ready_i = 1'b1;
    #1;
    chk("bp_rel_ready", 64'(in_ready_o), 64'd1);
    chk("bp_rel_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    chk("bp_drain", 64'(wb_valid_o), 64'd0);

    drive(1'b1, MDU_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, '0, 5'd9, 1'b1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk("mul_busy_stall", 64'(stall_o), 64'd1);
    lat = 0;
    while (!wb_valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mul_lat", 64'(lat), 64'd64);
    chk("mul_data", wb_data_o, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mul_rd", 64'(wb_rd_idx_o), 64'd9);

    issue(1'b1, MDU_MULHU, 1'b0, '1, 64'd2, '0, 5'd1, lat);
    chk("mulhu", wb_data_o, 64'd1);
    issue(1'b1, MDU_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, '0, 5'd1, lat);
    chk("mulh_neg", wb_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b1, MDU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '0, 5'd2, lat);
    chk("div_lat", 64'(lat), 64'd64);
    chk("div", wb_data_o, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(1'b1, MDU_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '0, 5'd2, lat);
    chk("rem", wb_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b1, MDU_DIV, 1'b1, 64'h8000_0000, '1, '0, 5'd3, lat);
    chk("divw_ovf_lat", 64'(lat), 64'd0);
    chk("divw_ovf", wb_data_o, 64'hFFFF_FFFF_8000_0000);
    issue(1'b1, MDU_DIVU, 1'b0, 64'd100, 64'd0, '0, 5'd4, lat);
    chk("divu_z_lat", 64'(lat), 64'd0);
    chk("divu_z", wb_data_o, '1);
    issue(1'b1, MDU_REMU, 1'b0, 64'd9, 64'd0, '0, 5'd4, lat);
    chk("remu_z", wb_data_o, 64'd9);

    drive(1'b0, 3'd0, 1'b0, '0, '0, 64'h55, 5'd0, 1'b0);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk("rd0_valid", 64'(wb_valid_o), 64'd1);
    chk("rd0_we", 64'(wb_rd_wr_en_o), 64'd0);

    drive(1'b1, MDU_DIVU, 1'b0, 64'd1000, 64'd3, '0, 5'd6, 1'b1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("kill_cnt", 64'(dut.cnt), 64'd20);
    kill_i = 1'b1;
    #1;
    chk("kill_noready", 64'(in_ready_o), 64'd0);
    @(posedge clk); #1;
    kill_i = 1'b0;
    #1;
    chk("kill_ready", 64'(in_ready_o), 64'd1);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (wb_valid_o) seen++;
    end
    chk("kill_no_wb", 64'(seen), 64'd0);
    issue(1'b1, MDU_DIVU, 1'b0, 64'd100, 64'd7, '0, 5'd8, lat);
    chk("post_kill_lat", 64'(lat), 64'd64);
    chk("post_kill_q", wb_data_o, 64'd14);

    drive(1'b1, MDU_MUL, 1'b0, 64'd11, 64'd13, '0, 5'd10, 1'b1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(wb_valid_o), 64'd0);
    chk("arst_data", wb_data_o, 64'd0);
    chk("arst_rd", 64'(wb_rd_idx_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_ready", 64'(in_ready_o), 64'd1);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (wb_valid_o) seen++;
    end
    chk("arst_no_wb", 64'(seen), 64'd0);
    issue(1'b1, MDU_MUL, 1'b1, 64'd6, 64'd7, '0, 5'd11, lat);
    chk("mulw_lat", 64'(lat), 64'd32);
    chk("mulw", wb_data_o, 64'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
